// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU interrupt controller: FSM states, register map, bus width.
// Pure declarations; no latency or backpressure of its own.
package cpu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADR_MASK = 2'd0;
  localparam logic [1:0] ADR_PEND = 2'd1;
  localparam logic [1:0] ADR_STAT = 2'd2;
  localparam logic [1:0] ADR_EOI  = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, zero latency.
// No backpressure: idx is meaningful only while vld is high.
module int_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             vld
);

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Edge-captured, masked, lowest-index-first interrupt controller; request rises one edge after pending is set.
// Port accesses get one registered ack per strobe; the CPU holds off a request simply by not acking it.
module cpu_int_ctrl
  import cpu_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_SRC-1:0]  src_i,
  output logic              int_req_o,
  output logic [ID_W-1:0]   int_id_o,
  input  logic              int_ack_i,
  output logic              in_service_o,
  input  logic              port_stb_i,
  input  logic              port_we_i,
  input  logic [1:0]        port_adr_i,
  input  logic [DATA_W-1:0] port_dat_i,
  output logic [DATA_W-1:0] port_dat_o,
  output logic              port_ack_o
);

  state_t             state, state_nxt;
  logic [N_SRC-1:0]   src_prev;
  logic [N_SRC-1:0]   pending, pending_nxt;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   src_edge;
  logic [N_SRC-1:0]   ack_clr;
  logic [N_SRC-1:0]   wr_clr;
  logic               req_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               svc_nxt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_vld;
  logic               acc_done;
  logic               acc_fire;
  logic               wr_fire;
  logic               mask_wr;
  logic               pend_wr;
  logic               eoi_wr;
  logic [DATA_W-1:0]  stat_dat;
  logic [DATA_W-1:0]  rd_dat;

  // acc_done keeps a long strobe from earning a second ack; it clears once stb drops.
  assign acc_fire = port_stb_i & ~acc_done;
  assign wr_fire  = acc_fire & port_we_i;
  assign mask_wr  = wr_fire & (port_adr_i == ADR_MASK);
  assign pend_wr  = wr_fire & (port_adr_i == ADR_PEND);
  assign eoi_wr   = wr_fire & (port_adr_i == ADR_EOI);

  assign src_edge = src_i & ~src_prev;
  assign wr_clr   = pend_wr ? port_dat_i[N_SRC-1:0] : '0;

  int_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req (pending & mask),
    .idx (arb_id),
    .vld (arb_vld)
  );

  always_comb begin
    stat_dat           = '0;
    stat_dat[DATA_W-1] = in_service_o;
    stat_dat[ID_W-1:0] = int_id_o;
  end

  always_comb begin
    rd_dat = '0;
    case (port_adr_i)
      ADR_MASK: rd_dat = DATA_W'(mask);
      ADR_PEND: rd_dat = DATA_W'(pending);
      ADR_STAT: rd_dat = stat_dat;
      default:  rd_dat = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = int_req_o;
    id_nxt    = int_id_o;
    svc_nxt   = in_service_o;
    ack_clr   = '0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          id_nxt    = arb_id;
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // A request withdrawn by software is dropped even if the ack lands the same cycle.
        if (!mask[int_id_o] || !pending[int_id_o]) begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (int_ack_i) begin
          ack_clr[int_id_o] = 1'b1;
          req_nxt   = 1'b0;
          svc_nxt   = 1'b1;
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) begin
          svc_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        svc_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // New edges are OR-ed in last so a set beats any same-cycle clear.
  assign pending_nxt = (pending & ~ack_clr & ~wr_clr) | src_edge;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      src_prev     <= '0;
      pending      <= '0;
      mask         <= '0;
      int_req_o    <= 1'b0;
      int_id_o     <= '0;
      in_service_o <= 1'b0;
      acc_done     <= 1'b0;
      port_ack_o   <= 1'b0;
      port_dat_o   <= '0;
    end else begin
      state        <= state_nxt;
      src_prev     <= src_i;
      pending      <= pending_nxt;
      int_req_o    <= req_nxt;
      int_id_o     <= id_nxt;
      in_service_o <= svc_nxt;
      if (mask_wr) begin
        mask <= port_dat_i[N_SRC-1:0];
      end
      acc_done     <= port_stb_i & (acc_done | acc_fire);
      port_ack_o   <= acc_fire;
      port_dat_o   <= (acc_fire && !port_we_i) ? rd_dat : '0;
    end
  end

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Self-checking bench for cpu_int_ctrl: directed scenarios plus randomized edges/masks against a pending-set model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_int_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] src_i;
  logic       int_req_o;
  logic [2:0] int_id_o;
  logic       int_ack_i;
  logic       in_service_o;
  logic       port_stb_i;
  logic       port_we_i;
  logic [1:0] port_adr_i;
  logic [7:0] port_dat_i;
  logic [7:0] port_dat_o;
  logic       port_ack_o;

  int n_pass  = 0;
  int n_total = 0;

  cpu_int_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .src_i        (src_i),
    .int_req_o    (int_req_o),
    .int_id_o     (int_id_o),
    .int_ack_i    (int_ack_i),
    .in_service_o (in_service_o),
    .port_stb_i   (port_stb_i),
    .port_we_i    (port_we_i),
    .port_adr_i   (port_adr_i),
    .port_dat_i   (port_dat_i),
    .port_dat_o   (port_dat_o),
    .port_ack_o   (port_ack_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic port_write(input logic [1:0] a, input logic [7:0] d);
    bit got = 1'b0;
    @(negedge clk);
    port_stb_i = 1'b1; port_we_i = 1'b1; port_adr_i = a; port_dat_i = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (port_ack_o) got = 1'b1;
    end
    port_stb_i = 1'b0; port_we_i = 1'b0;
    n_total++;
    if (!got) $display("FAIL write_ack adr %0d: got no ack required ack", a); else n_pass++;
  endtask

  task automatic port_read(input logic [1:0] a, output logic [7:0] d);
    bit got = 1'b0;
    d = 8'hxx;
    @(negedge clk);
    port_stb_i = 1'b1; port_we_i = 1'b0; port_adr_i = a;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (port_ack_o) begin got = 1'b1; d = port_dat_o; end
    end
    port_stb_i = 1'b0;
    n_total++;
    if (!got) $display("FAIL read_ack adr %0d: got no ack required ack", a); else n_pass++;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    @(negedge clk); src_i = v;
    @(negedge clk); src_i = 8'h00;
  endtask

  task automatic do_ack();
    int_ack_i = 1'b1;
    @(negedge clk);
    int_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_i = 1'b1; src_i = '0; int_ack_i = 0; port_stb_i = 0; port_we_i = 0; port_adr_i = 0; port_dat_i = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o, in_service_o, port_dat_o, port_ack_o} !== 14'h0)
      $display("FAIL reset_outputs: got %h required 0", {int_req_o, int_id_o, in_service_o, port_dat_o, port_ack_o});
    else n_pass++;
    rst_i = 1'b0;
    port_write(ADR_MASK, 8'h5A);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    n_total++;
    if ({int_req_o, int_id_o, in_service_o, port_dat_o, port_ack_o} !== 14'h0)
      $display("FAIL async_reset_outputs: got %h required 0", {int_req_o, int_id_o, in_service_o, port_dat_o, port_ack_o});
    else n_pass++;
    @(negedge clk) rst_i = 1'b0;
    port_read(ADR_MASK, d);
    n_total++; if (d !== 8'h00) $display("FAIL reset_mask: got %h required 00", d); else n_pass++;
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h00) $display("FAIL reset_pending: got %h required 00", d); else n_pass++;
  endtask

  task automatic test_basic_request();
    logic [7:0] d;
    port_write(ADR_MASK, 8'hFF);
    @(negedge clk); src_i = 8'h20;
    @(negedge clk); src_i = 8'h00;
    n_total++; if (int_req_o !== 1'b0) $display("FAIL req_early: got %b required 0", int_req_o); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o} !== {1'b1, 3'd5}) $display("FAIL req_id5: got %b/%0d required 1/5", int_req_o, int_id_o);
    else n_pass++;
    do_ack();
    n_total++;
    if ({int_req_o, in_service_o} !== 2'b01) $display("FAIL ack_service: got req/svc %b required 01", {int_req_o, in_service_o});
    else n_pass++;
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h00) $display("FAIL pend_after_ack: got %h required 00", d); else n_pass++;
  endtask

  task automatic test_port_protocol();
    logic [7:0] d = 8'h00;
    int acks = 0;
    @(negedge clk);
    port_stb_i = 1'b1; port_we_i = 1'b0; port_adr_i = ADR_STAT;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (port_ack_o) begin acks++; d = port_dat_o; end
    end
    port_stb_i = 1'b0;
    n_total++; if (acks != 1) $display("FAIL held_stb_acks: got %0d required 1", acks); else n_pass++;
    n_total++; if (d !== 8'h85) $display("FAIL status_svc5: got %h required 85", d); else n_pass++;
    @(negedge clk);
    n_total++; if ({port_ack_o, port_dat_o} !== 9'h0) $display("FAIL idle_port: got %h required 0", {port_ack_o, port_dat_o}); else n_pass++;
    port_write(ADR_EOI, 8'h00);
    n_total++; if (in_service_o !== 1'b0) $display("FAIL eoi_clears: got %b required 0", in_service_o); else n_pass++;
    port_write(ADR_EOI, 8'h00);
    repeat (2) @(negedge clk);
    n_total++;
    if ({int_req_o, in_service_o} !== 2'b00) $display("FAIL eoi_idle: got %b required 00", {int_req_o, in_service_o});
    else n_pass++;
    port_read(ADR_STAT, d);
    n_total++; if (d[7] !== 1'b0) $display("FAIL eoi_idle_status: got %h required bit7=0", d); else n_pass++;
  endtask

  task automatic test_priority();
    logic [7:0] d;
    pulse_src(8'h44);
    @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o} !== {1'b1, 3'd2}) $display("FAIL prio_first: got %b/%0d required 1/2", int_req_o, int_id_o);
    else n_pass++;
    do_ack();
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h40) $display("FAIL prio_pend: got %h required 40", d); else n_pass++;
    port_write(ADR_EOI, 8'h00);
    n_total++; if (int_req_o !== 1'b0) $display("FAIL prio_eoi_gap: got %b required 0", int_req_o); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o} !== {1'b1, 3'd6}) $display("FAIL prio_second: got %b/%0d required 1/6", int_req_o, int_id_o);
    else n_pass++;
    do_ack();
    port_write(ADR_EOI, 8'h00);
  endtask

  task automatic test_masking();
    logic [7:0] d;
    port_write(ADR_MASK, 8'h00);
    pulse_src(8'h02);
    repeat (3) @(negedge clk);
    n_total++; if (int_req_o !== 1'b0) $display("FAIL masked_req: got %b required 0", int_req_o); else n_pass++;
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h02) $display("FAIL masked_pend: got %h required 02", d); else n_pass++;
    port_write(ADR_MASK, 8'h02);
    @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o} !== {1'b1, 3'd1}) $display("FAIL unmask_req: got %b/%0d required 1/1", int_req_o, int_id_o);
    else n_pass++;
    port_write(ADR_MASK, 8'h00);
    @(negedge clk);
    n_total++;
    if ({int_req_o, in_service_o} !== 2'b00) $display("FAIL withdraw_req: got %b required 00", {int_req_o, in_service_o});
    else n_pass++;
    port_write(ADR_PEND, 8'h02);
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h00) $display("FAIL w1c_clear: got %h required 00", d); else n_pass++;
  endtask

  task automatic test_w1c_collision();
    logic [7:0] d;
    bit got = 1'b0;
    pulse_src(8'h08);
    @(negedge clk);
    src_i = 8'h08;
    port_stb_i = 1'b1; port_we_i = 1'b1; port_adr_i = ADR_PEND; port_dat_i = 8'h08;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (port_ack_o) got = 1'b1;
    end
    port_stb_i = 1'b0; port_we_i = 1'b0; src_i = 8'h00;
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h08) $display("FAIL set_wins: got %h required 08", d); else n_pass++;
    port_write(ADR_PEND, 8'h08);
  endtask

  task automatic test_level_and_reset();
    logic [7:0] d;
    @(negedge clk); src_i = 8'h01;
    repeat (10) @(negedge clk);
    src_i = 8'h00;
    port_write(ADR_MASK, 8'h01);
    @(negedge clk);
    n_total++;
    if ({int_req_o, int_id_o} !== {1'b1, 3'd0}) $display("FAIL level_req: got %b/%0d required 1/0", int_req_o, int_id_o);
    else n_pass++;
    do_ack();
    port_read(ADR_PEND, d);
    n_total++; if (d !== 8'h00) $display("FAIL level_single: got %h required 00", d); else n_pass++;
    port_write(ADR_EOI, 8'h00);
    repeat (2) @(negedge clk);
    n_total++; if (int_req_o !== 1'b0) $display("FAIL level_no_rereq: got %b required 0", int_req_o); else n_pass++;
    pulse_src(8'h01);
    @(negedge clk);
    do_ack();
    n_total++; if (in_service_o !== 1'b1) $display("FAIL pre_reset_svc: got %b required 1", in_service_o); else n_pass++;
    #2 rst_i = 1'b1;
    #1;
    n_total++;
    if ({int_req_o, in_service_o} !== 2'b00) $display("FAIL reset_mid_service: got %b required 00", {int_req_o, in_service_o});
    else n_pass++;
    @(negedge clk) rst_i = 1'b0;
    port_read(ADR_MASK, d);
    n_total++; if (d !== 8'h00) $display("FAIL reset_mid_mask: got %h required 00", d); else n_pass++;
  endtask

  // Model: pending is the OR of rising edges minus software clears and acked sources.
  task automatic test_random();
    logic [7:0] d, v, prev, model, m, c, active;
    int exp_id;
    for (int r = 0; r < 8; r++) begin
      port_write(ADR_MASK, 8'h00);
      port_write(ADR_PEND, 8'hFF);
      model = 8'h00; prev = 8'h00;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        v = 8'($urandom_range(0, 255));
        src_i = v;
        model = model | (v & ~prev);
        prev = v;
      end
      @(negedge clk) src_i = 8'h00;
      c = 8'($urandom_range(0, 255));
      port_write(ADR_PEND, c);
      model = model & ~c;
      port_read(ADR_PEND, d);
      n_total++; if (d !== model) $display("FAIL rnd_pend r%0d: got %h required %h", r, d, model); else n_pass++;
      m = 8'($urandom_range(0, 255));
      port_write(ADR_MASK, m);
      active = model & m;
      for (int it = 0; it < 9 && active != 8'h00; it++) begin
        exp_id = 0;
        for (int i = 7; i >= 0; i--) if (active[i]) exp_id = i;
        @(negedge clk);
        n_total++;
        if ({int_req_o, int_id_o} !== {1'b1, 3'(exp_id)})
          $display("FAIL rnd_req r%0d: got %b/%0d required 1/%0d", r, int_req_o, int_id_o, exp_id);
        else n_pass++;
        do_ack();
        n_total++; if (in_service_o !== 1'b1) $display("FAIL rnd_svc r%0d: got %b required 1", r, in_service_o); else n_pass++;
        model[exp_id] = 1'b0;
        port_write(ADR_EOI, 8'h00);
        active = model & m;
      end
      @(negedge clk);
      n_total++; if (int_req_o !== 1'b0) $display("FAIL rnd_drained r%0d: got %b required 0", r, int_req_o); else n_pass++;
      port_read(ADR_PEND, d);
      n_total++; if (d !== model) $display("FAIL rnd_left r%0d: got %h required %h", r, d, model); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_request();
    test_port_protocol();
    test_priority();
    test_masking();
    test_w1c_collision();
    test_level_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
